// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch front end: RISC-V opcodes,
// fetch FSM states and immediate extraction for JAL / conditional branches.
package fetch_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD,
    DROP
  } fetch_state_t;

  // Arguments keep their instruction bit positions so the scrambles read like the ISA manual.
  function automatic logic [31:0] imm_j(input logic [31:12] ins);
    return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:25] hi, input logic [11:7] lo);
    return {{20{hi[31]}}, lo[7], hi[30:25], lo[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_predecoder.sv
// Combinational predecode of one fetch block: per-slot next PC, the last slot
// that belongs to this fetch, and the PC of the following fetch.
// Backward conditional branches count as taken only with STATIC_BRANCH_PREDICT_EN.
module fetch_predecoder
  import fetch_pkg::*;
#(
  parameter int BW_PROCESSOR_BLOCK = 64,
  parameter int BW_PROCESSOR_DATA  = 32,
  parameter int BW_ADDRESS         = 32,
  parameter int NUM_GLOBAL_HISTORY = 4
) (
  input  logic [BW_PROCESSOR_BLOCK-1:0]   i_block,
  input  logic [BW_ADDRESS-1:0]           i_pc,
  input  logic [NUM_GLOBAL_HISTORY-1:0]   i_ghr,
  output logic [$clog2(BW_PROCESSOR_BLOCK/BW_PROCESSOR_DATA)+((BW_PROCESSOR_BLOCK/BW_PROCESSOR_DATA)<=1)-1:0] o_upperbound,
  output logic [BW_PROCESSOR_BLOCK-1:0]   o_pc_next_flatten,
  output logic [BW_ADDRESS-1:0]           o_fetch_next,
  output logic [NUM_GLOBAL_HISTORY-1:0]   o_ghr
);

  localparam int NUM_FIFO_INPUT_ENTRY = BW_PROCESSOR_BLOCK / BW_PROCESSOR_DATA;
  localparam int BW_PC_MOD = $clog2(NUM_FIFO_INPUT_ENTRY) + (NUM_FIFO_INPUT_ENTRY <= 1);

  logic [BW_PC_MOD-1:0]         pc_mod;
  logic [BW_ADDRESS-1:0]        base;
  logic [BW_ADDRESS-1:0]        slot_pc   [NUM_FIFO_INPUT_ENTRY];
  logic [BW_ADDRESS-1:0]        slot_next [NUM_FIFO_INPUT_ENTRY];
  logic [BW_PROCESSOR_DATA-1:0] slot_ins  [NUM_FIFO_INPUT_ENTRY];
  logic [NUM_FIFO_INPUT_ENTRY-1:0] slot_taken;
  logic                         found;

  // The prediction travels with the history it was made under.
  assign o_ghr = i_ghr;

  assign pc_mod = i_pc[BW_PC_MOD+1:2];
  assign base   = {i_pc[BW_ADDRESS-1:BW_PC_MOD+2], {(BW_PC_MOD+2){1'b0}}};

  // NOTE: every variable written in an always_comb gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    for (int i = 0; i < NUM_FIFO_INPUT_ENTRY; i++) begin
      slot_ins[i]   = i_block[i*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA];
      slot_pc[i]    = base + BW_ADDRESS'(4 * i);
      slot_next[i]  = slot_pc[i] + BW_ADDRESS'(4);
      slot_taken[i] = 1'b0;
      case (slot_ins[i][6:0])
        OPC_JAL: begin
          slot_next[i]  = slot_pc[i] + BW_ADDRESS'($signed(imm_j(slot_ins[i][31:12])));
          slot_taken[i] = 1'b1;
        end
        OPC_BRANCH: begin
`ifdef STATIC_BRANCH_PREDICT_EN
          if (slot_ins[i][31]) begin
            slot_next[i]  = slot_pc[i] +
                            BW_ADDRESS'($signed(imm_b(slot_ins[i][31:25], slot_ins[i][11:7])));
            slot_taken[i] = 1'b1;
          end
`endif
        end
        OPC_JALR: slot_next[i] = slot_pc[i] + BW_ADDRESS'(4);
        default:  slot_next[i] = slot_pc[i] + BW_ADDRESS'(4);
      endcase
    end
  end

  always_comb begin
    o_upperbound      = BW_PC_MOD'(NUM_FIFO_INPUT_ENTRY - 1);
    found             = 1'b0;
    o_pc_next_flatten = '0;
    for (int i = 0; i < NUM_FIFO_INPUT_ENTRY; i++) begin
      if (!found && BW_PC_MOD'(i) >= pc_mod && slot_taken[i]) begin
        o_upperbound = BW_PC_MOD'(i);
        found        = 1'b1;
      end
    end
    for (int i = 0; i < NUM_FIFO_INPUT_ENTRY; i++) begin
      if (BW_PC_MOD'(i) >= pc_mod && BW_PC_MOD'(i) <= o_upperbound)
        o_pc_next_flatten[i*BW_ADDRESS +: BW_ADDRESS] = slot_next[i];
    end
    o_fetch_next = slot_next[o_upperbound];
  end

  // Register fields and pc byte offset are not needed for prediction.
  logic unused_inputs;
  assign unused_inputs = ^{i_block, i_pc[1:0]};

endmodule

// File: rtl/fetch_unit.sv
// Fetch PC owner and instruction-queue producer: REQ -> WAIT -> HOLD loop with
// flush redirect and stale-response DROP. Optional macro: STATIC_BRANCH_PREDICT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int BW_PROCESSOR_BLOCK = 64,
  parameter int BW_PROCESSOR_DATA  = 32,
  parameter int BW_ADDRESS         = 32,
  parameter int NUM_GLOBAL_HISTORY = 4,
  parameter logic [BW_ADDRESS-1:0] RESET_PC = '0,
  localparam int NUM_FIFO_INPUT_ENTRY = BW_PROCESSOR_BLOCK / BW_PROCESSOR_DATA,
  localparam int BW_PC_MOD = $clog2(NUM_FIFO_INPUT_ENTRY) + (NUM_FIFO_INPUT_ENTRY <= 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          o_imem_valid,
  input  logic                          o_imem_ready,
  output logic [BW_ADDRESS-1:0]         o_imem_addr,
  input  logic                          i_imem_valid,
  output logic                          i_imem_ready,
  input  logic [BW_PROCESSOR_BLOCK-1:0] i_imem_data,
  output logic                          o_iq_valid,
  input  logic                          o_iq_ready,
  output logic [BW_PROCESSOR_BLOCK-1:0] o_iq_instruction_flatten,
  output logic [BW_ADDRESS-1:0]         o_iq_pc,
  output logic [BW_PC_MOD-1:0]          o_iq_pc_upperbound,
  output logic [NUM_GLOBAL_HISTORY-1:0] o_iq_global_history,
  output logic [BW_PROCESSOR_BLOCK-1:0] o_iq_pc_next_flatten,
  input  logic                          i_branch_valid,
  input  logic                          i_branch_flush,
  input  logic [BW_ADDRESS-1:0]         i_branch_target,
  input  logic                          i_branch_is_cond,
  input  logic                          i_branch_taken,
  input  logic [NUM_GLOBAL_HISTORY-1:0] i_branch_global_history
);

  fetch_state_t                  state_q, state_d;
  logic [BW_ADDRESS-1:0]         pc_q, pc_d;
  logic [NUM_GLOBAL_HISTORY-1:0] ghr_q, ghr_d;
  logic [BW_PROCESSOR_BLOCK-1:0] block_q, block_d;
  logic [BW_ADDRESS-1:0]         iq_pc_q, iq_pc_d;
  logic [BW_PC_MOD-1:0]          ub_q, ub_d;
  logic [BW_PROCESSOR_BLOCK-1:0] pc_next_q, pc_next_d;
  logic [BW_ADDRESS-1:0]         fetch_next_q, fetch_next_d;
  logic [NUM_GLOBAL_HISTORY-1:0] iq_ghr_q, iq_ghr_d;

  logic [BW_PC_MOD-1:0]          pd_ub;
  logic [BW_PROCESSOR_BLOCK-1:0] pd_pc_next;
  logic [BW_ADDRESS-1:0]         pd_fetch_next;
  logic [NUM_GLOBAL_HISTORY-1:0] pd_ghr;
  logic                          flush;

  fetch_predecoder #(
    .BW_PROCESSOR_BLOCK (BW_PROCESSOR_BLOCK),
    .BW_PROCESSOR_DATA  (BW_PROCESSOR_DATA),
    .BW_ADDRESS         (BW_ADDRESS),
    .NUM_GLOBAL_HISTORY (NUM_GLOBAL_HISTORY)
  ) u_predecoder (
    .i_block           (i_imem_data),
    .i_pc              (pc_q),
    .i_ghr             (ghr_q),
    .o_upperbound      (pd_ub),
    .o_pc_next_flatten (pd_pc_next),
    .o_fetch_next      (pd_fetch_next),
    .o_ghr             (pd_ghr)
  );

  assign flush = i_branch_valid && i_branch_flush;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ghr_d        = ghr_q;
    block_d      = block_q;
    iq_pc_d      = iq_pc_q;
    ub_d         = ub_q;
    pc_next_d    = pc_next_q;
    fetch_next_d = fetch_next_q;
    iq_ghr_d     = iq_ghr_q;

    if (i_branch_valid && i_branch_is_cond)
      ghr_d = {i_branch_global_history[NUM_GLOBAL_HISTORY-2:0], i_branch_taken};

    if (flush) begin
      pc_d = i_branch_target;
      // A request already accepted, or a response still owed, must be swallowed in DROP.
      case (state_q)
        REQ:     state_d = o_imem_ready ? DROP : REQ;
        WAIT:    state_d = i_imem_valid ? REQ : DROP;
        HOLD:    state_d = REQ;
        default: state_d = DROP;
      endcase
    end else begin
      case (state_q)
        REQ:  if (o_imem_ready) state_d = WAIT;
        WAIT: if (i_imem_valid) begin
          block_d      = i_imem_data;
          iq_pc_d      = pc_q;
          ub_d         = pd_ub;
          pc_next_d    = pd_pc_next;
          fetch_next_d = pd_fetch_next;
          iq_ghr_d     = pd_ghr;
          state_d      = HOLD;
        end
        HOLD: if (o_iq_ready) begin
          pc_d    = fetch_next_q;
          state_d = REQ;
        end
        default: if (i_imem_valid) state_d = REQ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      ghr_q        <= '0;
      block_q      <= '0;
      iq_pc_q      <= '0;
      ub_q         <= '0;
      pc_next_q    <= '0;
      fetch_next_q <= '0;
      iq_ghr_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ghr_q        <= ghr_d;
      block_q      <= block_d;
      iq_pc_q      <= iq_pc_d;
      ub_q         <= ub_d;
      pc_next_q    <= pc_next_d;
      fetch_next_q <= fetch_next_d;
      iq_ghr_q     <= iq_ghr_d;
    end
  end

  // REQ is the reset state, so the request is masked while reset is held.
  assign o_imem_valid = !rst && (state_q == REQ);
  assign o_imem_addr  = o_imem_valid
                      ? {pc_q[BW_ADDRESS-1:BW_PC_MOD+2], {(BW_PC_MOD+2){1'b0}}} : '0;
  assign i_imem_ready = (state_q == WAIT) || (state_q == DROP);

  assign o_iq_valid               = (state_q == HOLD);
  assign o_iq_instruction_flatten = block_q;
  assign o_iq_pc                  = iq_pc_q;
  assign o_iq_pc_upperbound       = ub_q;
  assign o_iq_global_history      = iq_ghr_q;
  assign o_iq_pc_next_flatten     = pc_next_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of expected IQ blocks pushed when a
// memory response is driven and popped when the DUT presents the block.
module tb_fetch_unit;

  localparam logic [31:0] ADDI     = 32'h00100093;
  localparam logic [31:0] NOP      = 32'h00000013;
  localparam logic [31:0] JAL_P10  = 32'h0100006F;
  localparam logic [31:0] JAL_M8   = 32'hFF9FF06F;
  localparam logic [31:0] BEQ_M8   = 32'hFE000CE3;

  typedef struct {
    logic [31:0] pc;
    logic        ub;
    logic [63:0] next;
    logic [3:0]  ghr;
    logic [63:0] block;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        o_imem_valid, o_imem_ready;
  logic [31:0] o_imem_addr;
  logic        i_imem_valid, i_imem_ready;
  logic [63:0] i_imem_data;
  logic        o_iq_valid, o_iq_ready;
  logic [63:0] o_iq_instruction_flatten;
  logic [31:0] o_iq_pc;
  logic [0:0]  o_iq_pc_upperbound;
  logic [3:0]  o_iq_global_history;
  logic [63:0] o_iq_pc_next_flatten;
  logic        i_branch_valid, i_branch_flush, i_branch_is_cond, i_branch_taken;
  logic [31:0] i_branch_target;
  logic [3:0]  i_branch_global_history;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  fetch_unit dut (
    .clk                      (clk),
    .rst                      (rst),
    .o_imem_valid             (o_imem_valid),
    .o_imem_ready             (o_imem_ready),
    .o_imem_addr              (o_imem_addr),
    .i_imem_valid             (i_imem_valid),
    .i_imem_ready             (i_imem_ready),
    .i_imem_data              (i_imem_data),
    .o_iq_valid               (o_iq_valid),
    .o_iq_ready               (o_iq_ready),
    .o_iq_instruction_flatten (o_iq_instruction_flatten),
    .o_iq_pc                  (o_iq_pc),
    .o_iq_pc_upperbound       (o_iq_pc_upperbound),
    .o_iq_global_history      (o_iq_global_history),
    .o_iq_pc_next_flatten     (o_iq_pc_next_flatten),
    .i_branch_valid           (i_branch_valid),
    .i_branch_flush           (i_branch_flush),
    .i_branch_target          (i_branch_target),
    .i_branch_is_cond         (i_branch_is_cond),
    .i_branch_taken           (i_branch_taken),
    .i_branch_global_history  (i_branch_global_history)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a memory request and check its address; does not accept it.
  task automatic wait_req(input string tag, input logic [31:0] addr);
    int n = 0;
    while (!o_imem_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req_valid"}, 64'(o_imem_valid), 64'd1);
    check({tag, "_req_addr"}, 64'(o_imem_addr), 64'(addr));
  endtask

  task automatic branch(input logic flush, input logic [31:0] tgt, input logic is_cond,
                        input logic taken, input logic [3:0] hist);
    i_branch_valid = 1'b1;
    i_branch_flush = flush;
    i_branch_target = tgt;
    i_branch_is_cond = is_cond;
    i_branch_taken = taken;
    i_branch_global_history = hist;
    @(negedge clk);
    i_branch_valid = 1'b0;
    i_branch_flush = 1'b0;
    i_branch_is_cond = 1'b0;
  endtask

  // One full fetch: accept the request, answer with data, compare the IQ block
  // against the scoreboard for hold+1 cycles, then accept (optionally with a flush).
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [63:0] data,
                       input exp_t e, input int hold, input logic flush_acc,
                       input logic [31:0] tgt);
    exp_t got;
    int   n = 0;
    wait_req(tag, addr);
    o_imem_ready = 1'b1;
    @(negedge clk);
    o_imem_ready = 1'b0;
    check({tag, "_wait_ready"}, 64'(i_imem_ready), 64'd1);
    i_imem_valid = 1'b1;
    i_imem_data = data;
    sb.push_back(e);
    @(negedge clk);
    i_imem_valid = 1'b0;
    while (!o_iq_valid && n < 5) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_iq_valid"}, 64'(o_iq_valid), 64'd1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      for (int k = 0; k <= hold; k++) begin
        check({tag, "_iq_valid_held"}, 64'(o_iq_valid), 64'd1);
        check({tag, "_pc"}, 64'(o_iq_pc), 64'(got.pc));
        check({tag, "_ub"}, 64'(o_iq_pc_upperbound), 64'(got.ub));
        check({tag, "_pc_next"}, o_iq_pc_next_flatten, got.next);
        check({tag, "_ghr"}, 64'(o_iq_global_history), 64'(got.ghr));
        check({tag, "_block"}, o_iq_instruction_flatten, got.block);
        if (k < hold) @(negedge clk);
      end
    end
    o_iq_ready = 1'b1;
    if (flush_acc) begin
      i_branch_valid = 1'b1;
      i_branch_flush = 1'b1;
      i_branch_target = tgt;
    end
    @(negedge clk);
    o_iq_ready = 1'b0;
    i_branch_valid = 1'b0;
    i_branch_flush = 1'b0;
    check({tag, "_iq_valid_drop"}, 64'(o_iq_valid), 64'd0);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] after_addr;

    rst = 1'b1;
    o_imem_ready = 1'b0;
    i_imem_valid = 1'b0;
    i_imem_data = '0;
    o_iq_ready = 1'b0;
    i_branch_valid = 1'b0;
    i_branch_flush = 1'b0;
    i_branch_target = '0;
    i_branch_is_cond = 1'b0;
    i_branch_taken = 1'b0;
    i_branch_global_history = '0;
    repeat (2) @(negedge clk);
    check("rst_imem_valid", 64'(o_imem_valid), 64'd0);
    check("rst_imem_addr", 64'(o_imem_addr), 64'd0);
    check("rst_imem_ready", 64'(i_imem_ready), 64'd0);
    check("rst_iq_valid", 64'(o_iq_valid), 64'd0);
    check("rst_iq_pc", 64'(o_iq_pc), 64'd0);
    check("rst_iq_ub", 64'(o_iq_pc_upperbound), 64'd0);
    check("rst_iq_ghr", 64'(o_iq_global_history), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Straight-line block from the reset PC.
    e = '{pc: 32'h0, ub: 1'b1, next: {32'h8, 32'h4}, ghr: 4'h0, block: {ADDI, ADDI}};
    fetch("f0", 32'h0, {ADDI, ADDI}, e, 0, 1'b0, 32'h0);
    wait_req("f0_next", 32'h8);

    // Redirect into slot 1; JAL +0x10 there.
    branch(1'b1, 32'h4, 1'b0, 1'b0, 4'h0);
    e = '{pc: 32'h4, ub: 1'b1, next: {32'h14, 32'h0}, ghr: 4'h0, block: {JAL_P10, NOP}};
    fetch("f1", 32'h0, {JAL_P10, NOP}, e, 0, 1'b0, 32'h0);
    wait_req("f1_next", 32'h10);

    // JAL -8 in slot 0 ends the block early.
    branch(1'b1, 32'h20, 1'b0, 1'b0, 4'h0);
    e = '{pc: 32'h20, ub: 1'b0, next: {32'h0, 32'h18}, ghr: 4'h0, block: {NOP, JAL_M8}};
    fetch("f2", 32'h20, {NOP, JAL_M8}, e, 0, 1'b0, 32'h0);

    // Flush in WAIT; the late response must be swallowed.
    wait_req("f3", 32'h18);
    o_imem_ready = 1'b1;
    @(negedge clk);
    o_imem_ready = 1'b0;
    branch(1'b1, 32'h100, 1'b0, 1'b0, 4'h0);
    check("drop_iq_valid", 64'(o_iq_valid), 64'd0);
    check("drop_imem_valid", 64'(o_imem_valid), 64'd0);
    check("drop_imem_ready", 64'(i_imem_ready), 64'd1);
    i_imem_valid = 1'b1;
    i_imem_data = {ADDI, JAL_M8};
    @(negedge clk);
    i_imem_valid = 1'b0;
    check("drop_after_iq_valid", 64'(o_iq_valid), 64'd0);

    // Stall in HOLD for 5 cycles, then accept together with a flush.
    e = '{pc: 32'h100, ub: 1'b1, next: {32'h108, 32'h104}, ghr: 4'h0, block: {ADDI, ADDI}};
    fetch("f4", 32'h100, {ADDI, ADDI}, e, 5, 1'b1, 32'h28);

    // Backward beq in slot 0 at 0x28.
`ifdef STATIC_BRANCH_PREDICT_EN
    e = '{pc: 32'h28, ub: 1'b0, next: {32'h0, 32'h20}, ghr: 4'h0, block: {ADDI, BEQ_M8}};
    after_addr = 32'h20;
`else
    e = '{pc: 32'h28, ub: 1'b1, next: {32'h30, 32'h2C}, ghr: 4'h0, block: {ADDI, BEQ_M8}};
    after_addr = 32'h30;
`endif
    fetch("f5", 32'h28, {ADDI, BEQ_M8}, e, 0, 1'b0, 32'h0);

    // Resolved taken conditional branch rebuilds the history.
    branch(1'b0, 32'h0, 1'b1, 1'b1, 4'b0101);
    e = '{pc: after_addr, ub: 1'b1, next: {after_addr + 32'h8, after_addr + 32'h4},
          ghr: 4'b1011, block: {ADDI, ADDI}};
    fetch("f6", after_addr, {ADDI, ADDI}, e, 0, 1'b0, 32'h0);
    wait_req("f6_next", after_addr + 32'h8);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
